// File: rtl/fetch_pc_ctrl.sv
// Fetch-side PC sequencer: holds the fetch PC, drives IMEM req/ack reads, feeds PC+STEP to the branch adder.
// Latency: inst_valid/pc_out register one cycle after imem_ack; imem_req/stop/pc4 are combinational from state.
// Backpressure: stall blocks new fetches (an outstanding request still completes); imem_addr holds until imem_ack.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   stall           hazard-unit stall, no new fetch issued while high
//   br_taken, bnq   1-cycle taken-branch pulse and its target from the branch adder
//   imem_req/addr   IMEM read request and address; imem_ack marks read complete
//   pc_out          address of the instruction flagged by inst_valid
//   pc4             imem_addr + STEP (modulo 2^WIDTH) to branch adder A input
//   stop            freeze branch adder (stall, BOOT or SQUASH)
//   inst_valid      1-cycle pulse for each non-squashed completed fetch
//   align_err       sticky misaligned-redirect flag, present only with FETCH_ALIGN_CHECK_EN
//
// Build option: define FETCH_ALIGN_CHECK_EN to add align_err and force redirect targets word-aligned.

module fetch_pc_ctrl #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               STEP     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] bnq,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc4,
  output logic             stop,
  output logic             inst_valid
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic             align_err
`endif
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  typedef enum logic [1:0] {BOOT, FETCH, HOLD, SQUASH} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] redir_q;
  logic [WIDTH-1:0] tgt;
  logic             vld_q, vld_d;

`ifdef FETCH_ALIGN_CHECK_EN
  logic align_q;
  assign tgt       = {bnq[WIDTH-1:2], 2'b00};
  assign align_err = align_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      align_q <= 1'b0;
    else if (br_taken && (bnq[1:0] != 2'b00))
      align_q <= 1'b1;
  end
`else
  assign tgt = bnq;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pc_d    = pc_q;
    vld_d   = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = stall ? HOLD : FETCH;
        if (br_taken) addr_d = tgt;
      end
      FETCH: begin
        if (imem_ack) begin
          state_d = stall ? HOLD : FETCH;
          if (br_taken) begin
            // Branch resolved in the ack cycle: drop this instruction.
            addr_d = tgt;
          end else begin
            vld_d  = 1'b1;
            pc_d   = addr_q;
            addr_d = addr_q + STEP_W;
          end
        end else if (br_taken) begin
          // Request already on the bus; must wait for its ack before redirecting.
          state_d = SQUASH;
        end
      end
      HOLD: begin
        if (!stall) state_d = FETCH;
        if (br_taken) addr_d = tgt;
      end
      SQUASH: begin
        if (imem_ack) begin
          state_d = stall ? HOLD : FETCH;
          // A branch arriving with the ack is newer than the captured one.
          addr_d  = br_taken ? tgt : redir_q;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BOOT;
      addr_q  <= RESET_PC;
      pc_q    <= RESET_PC;
      redir_q <= RESET_PC;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pc_q    <= pc_d;
      vld_q   <= vld_d;
      if (br_taken) redir_q <= tgt;
    end
  end

  assign imem_req   = (state_q == FETCH) || (state_q == SQUASH);
  assign imem_addr  = addr_q;
  assign pc4        = addr_q + STEP_W;
  assign stop       = stall || (state_q == BOOT) || (state_q == SQUASH);
  assign pc_out     = pc_q;
  assign inst_valid = vld_q;

endmodule
